tap_bank_mem: RTL and testbench

Parametrised tap-coefficient store for the neural datapath: LANES independent DATA_W-wide memory lanes of DEPTH words each, read and written as one LANES*DATA_W word. Adds a pipelined read-modify-write update path for coefficient training with hazard forwarding. Keeps the single-lane sub-write and the interleave counters that sequence tap fetches. Sits between the stage controller and the MAC array, one instance per stage.

---
 rtl/tap_bank_mem.sv | 175 +++++++++++++++++
 tb/tb_tap_bank_mem.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_bank_mem.sv
// Multi-lane tap-coefficient store: full/sub-lane writes, registered reads and interleave counters.
// Optional macro TAP_BANK_UPDATE_EN adds the forwarded read-modify-write update pipeline and wr_drop.
module tap_bank_mem #(
  parameter  int unsigned LANES  = 6,
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned SW     = $clog2(LANES),
  localparam int unsigned WORD_W = LANES * DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_vld,
  input  logic [AW-1:0]     rd_address,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_data_vld,
  input  logic              wr_vld,
  input  logic [AW-1:0]     wr_address,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              sub_vld,
  input  logic [SW-1:0]     sub_addr,
  input  logic [DATA_W-1:0] sub_data,
  input  logic              upd_vld,
  input  logic [AW-1:0]     upd_address,
  input  logic [WORD_W-1:0] upd_delta,
  output logic              wr_drop,
  input  logic              inter,
  input  logic              inter_first,
  output logic [SW-1:0]     inter_count_0,
  output logic [AW-1:0]     inter_count_1
);

  logic [DATA_W-1:0] mem [LANES][DEPTH];

  logic [WORD_W-1:0] rd_word;

  // All lanes read together at the external read address
  always_comb begin
    rd_word = '0;
    for (int l = 0; l < LANES; l++) begin
      rd_word[l*DATA_W +: DATA_W] = mem[l][rd_address];
    end
  end

  // Writeback port from the update pipeline; inert when the pipeline is not built
  logic              wb_vld;
  logic [AW-1:0]     wb_addr;
  logic [WORD_W-1:0] wb_data;

`ifdef TAP_BANK_UPDATE_EN
  logic              u2_vld;
  logic [AW-1:0]     u2_addr;
  logic [WORD_W-1:0] u2_delta;
  logic [WORD_W-1:0] u2_base;
  logic [WORD_W-1:0] u2_sum;
  logic [WORD_W-1:0] u1_word;

  // U2: lane-wise wrapping add of the captured base and delta
  always_comb begin
    u2_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      u2_sum[l*DATA_W +: DATA_W] = u2_base[l*DATA_W +: DATA_W] + u2_delta[l*DATA_W +: DATA_W];
    end
  end

  // U1: read the target word, taking the in-flight sum when U2 is writing the same address
  always_comb begin
    u1_word = '0;
    for (int l = 0; l < LANES; l++) begin
      u1_word[l*DATA_W +: DATA_W] = mem[l][upd_address];
    end
    if (u2_vld && (u2_addr == upd_address)) begin
      u1_word = u2_sum;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      u2_vld   <= 1'b0;
      u2_addr  <= '0;
      u2_delta <= '0;
      u2_base  <= '0;
    end else begin
      u2_vld <= upd_vld;
      if (upd_vld) begin
        u2_addr  <= upd_address;
        u2_delta <= upd_delta;
        u2_base  <= u1_word;
      end
    end
  end

  assign wb_vld  = u2_vld;
  assign wb_addr = u2_addr;
  assign wb_data = u2_sum;
`else
  logic unused_upd;
  assign unused_upd = ^{upd_vld, upd_address, upd_delta};

  assign wb_vld  = 1'b0;
  assign wb_addr = '0;
  assign wb_data = '0;
`endif

  logic              sub_hit;
  logic              ext_req;
  logic [LANES-1:0]  we;
  logic [AW-1:0]     wa;
  logic [WORD_W-1:0] wd;

  // Single write port: update writeback beats sub write beats full write
  always_comb begin
    sub_hit = sub_vld && (32'(sub_addr) < LANES);
    ext_req = sub_hit || (wr_vld && !sub_vld);
    we      = '0;
    wa      = wr_address;
    wd      = wr_data;
    if (wb_vld) begin
      we = '1;
      wa = wb_addr;
      wd = wb_data;
    end else if (sub_vld) begin
      for (int l = 0; l < LANES; l++) begin
        wd[l*DATA_W +: DATA_W] = sub_data;
        if (sub_hit && (sub_addr == SW'(l))) begin
          we[l] = 1'b1;
        end
      end
    end else if (wr_vld) begin
      we = '1;
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we[l]) begin
        mem[l][wa] <= wd[l*DATA_W +: DATA_W];
      end
    end
  end

  // Registered read data, valid strobe and dropped-write pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data     <= '0;
      rd_data_vld <= 1'b0;
      wr_drop     <= 1'b0;
    end else begin
      rd_data_vld <= rd_vld;
      if (rd_vld) begin
        rd_data <= rd_word;
      end
      wr_drop <= wb_vld && ext_req;
    end
  end

  // Interleave counters: lane phase wraps at LANES, carrying into the word phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inter_count_0 <= '0;
      inter_count_1 <= '0;
    end else if (inter_first) begin
      inter_count_0 <= '0;
      inter_count_1 <= '0;
    end else if (inter) begin
      if (inter_count_0 == SW'(LANES - 1)) begin
        inter_count_0 <= '0;
        inter_count_1 <= (inter_count_1 == AW'(DEPTH - 1)) ? '0 : inter_count_1 + AW'(1);
      end else begin
        inter_count_0 <= inter_count_0 + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tap_bank_mem.sv
// Directed self-checking bench for tap_bank_mem against a committed-state memory model.
module tb_tap_bank_mem;
  localparam int unsigned LANES  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned AW     = 2;
  localparam int unsigned SW     = 3;
  localparam int unsigned WW     = LANES * DATA_W;
`ifdef TAP_BANK_UPDATE_EN
  localparam bit UPD_EN = 1'b1;
`else
  localparam bit UPD_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rd_vld;
  logic [AW-1:0]     rd_address;
  logic [WW-1:0]     rd_data;
  logic              rd_data_vld;
  logic              wr_vld;
  logic [AW-1:0]     wr_address;
  logic [WW-1:0]     wr_data;
  logic              sub_vld;
  logic [SW-1:0]     sub_addr;
  logic [DATA_W-1:0] sub_data;
  logic              upd_vld;
  logic [AW-1:0]     upd_address;
  logic [WW-1:0]     upd_delta;
  logic              wr_drop;
  logic              inter;
  logic              inter_first;
  logic [SW-1:0]     inter_count_0;
  logic [AW-1:0]     inter_count_1;

  tap_bank_mem #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n),
    .rd_vld(rd_vld), .rd_address(rd_address), .rd_data(rd_data), .rd_data_vld(rd_data_vld),
    .wr_vld(wr_vld), .wr_address(wr_address), .wr_data(wr_data),
    .sub_vld(sub_vld), .sub_addr(sub_addr), .sub_data(sub_data),
    .upd_vld(upd_vld), .upd_address(upd_address), .upd_delta(upd_delta),
    .wr_drop(wr_drop), .inter(inter), .inter_first(inter_first),
    .inter_count_0(inter_count_0), .inter_count_1(inter_count_1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] ramp(input logic [DATA_W-1:0] b);
    logic [WW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*DATA_W +: DATA_W] = b + DATA_W'(l);
    return r;
  endfunction

  function automatic logic [WW-1:0] splat(input logic [DATA_W-1:0] v);
    logic [WW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  // Model: committed memory, an update lands one cycle after its request and adds to whatever is committed then
  logic [DATA_W-1:0] m_mem [LANES][DEPTH];
  logic [WW-1:0]     m_rd;
  logic              m_rd_vld;
  logic              m_drop;
  int                m_c0;
  int                m_c1;
  logic              p_vld;
  logic [AW-1:0]     p_addr;
  logic [WW-1:0]     p_delta;
  logic              m_ext;

  assign m_ext = (sub_vld && (sub_addr < LANES)) || (wr_vld && !sub_vld);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rd     <= '0;
      m_rd_vld <= 1'b0;
      m_drop   <= 1'b0;
      m_c0     <= 0;
      m_c1     <= 0;
      p_vld    <= 1'b0;
    end else begin
      m_rd_vld <= rd_vld;
      if (rd_vld)
        for (int l = 0; l < LANES; l++) m_rd[l*DATA_W +: DATA_W] <= m_mem[l][rd_address];
      if (UPD_EN && p_vld) begin
        for (int l = 0; l < LANES; l++)
          m_mem[l][p_addr] <= m_mem[l][p_addr] + p_delta[l*DATA_W +: DATA_W];
      end else if (sub_vld) begin
        if (sub_addr < LANES) m_mem[sub_addr][wr_address] <= sub_data;
      end else if (wr_vld) begin
        for (int l = 0; l < LANES; l++) m_mem[l][wr_address] <= wr_data[l*DATA_W +: DATA_W];
      end
      m_drop  <= UPD_EN && p_vld && m_ext;
      p_vld   <= UPD_EN && upd_vld;
      p_addr  <= upd_address;
      p_delta <= upd_delta;
      if (inter_first) begin
        m_c0 <= 0;
        m_c1 <= 0;
      end else if (inter) begin
        m_c0 <= (m_c0 + 1) % LANES;
        if (m_c0 == LANES - 1) m_c1 <= (m_c1 + 1) % DEPTH;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_data_vld", WW'(rd_data_vld), WW'(m_rd_vld));
      chk("rd_data", rd_data, m_rd);
      chk("wr_drop", WW'(wr_drop), WW'(m_drop));
      chk("inter_count_0", WW'(inter_count_0), WW'(m_c0));
      chk("inter_count_1", WW'(inter_count_1), WW'(m_c1));
    end
  end

  task automatic clr();
    rd_vld = 1'b0; rd_address = '0; wr_vld = 1'b0; wr_address = '0; wr_data = '0;
    sub_vld = 1'b0; sub_addr = '0; sub_data = '0; upd_vld = 1'b0; upd_address = '0;
    upd_delta = '0; inter = 1'b0; inter_first = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [WW-1:0] exp_sub;
  int            seq0 [14] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1, 2};

  initial begin
    clr();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("reset rd_data_vld", WW'(rd_data_vld), WW'(0));
    chk("reset rd_data", rd_data, '0);
    chk("reset count_0", WW'(inter_count_0), WW'(0));
    rst_n = 1'b1;

    // Fill every word: addr0 ramp A0, addr1 all 5, addr2 ramp 10, addr3 ramp 30
    for (int a = 0; a < 4; a++) begin
      wr_vld = 1'b1; wr_address = AW'(a);
      case (a)
        0: wr_data = ramp(32'hA0);
        1: wr_data = splat(32'h5);
        2: wr_data = ramp(32'h10);
        default: wr_data = ramp(32'h30);
      endcase
      tick();
    end

    clr(); rd_vld = 1'b1; rd_address = 2; tick();
    chk("lit read addr2 vld", WW'(rd_data_vld), WW'(1));
    chk("lit read addr2 data", rd_data, ramp(32'h10));
    clr(); tick();
    chk("lit vld pulse low", WW'(rd_data_vld), WW'(0));
    chk("lit rd_data held", rd_data, ramp(32'h10));

    // Sub write wins over full write; out-of-range lane writes nothing
    sub_vld = 1'b1; sub_addr = 3; sub_data = 32'hDEAD;
    wr_vld = 1'b1; wr_address = 2; wr_data = splat(32'hFF); tick();
    sub_addr = 7; sub_data = 32'hBEEF; tick();
    clr(); rd_vld = 1'b1; rd_address = 2; tick();
    exp_sub = ramp(32'h10);
    exp_sub[3*DATA_W +: DATA_W] = 32'hDEAD;
    chk("lit sub write lane3", rd_data, exp_sub);

    // Back-to-back updates to one address accumulate
    clr(); upd_vld = 1'b1; upd_address = 1; upd_delta = splat(32'h3); tick(); tick();
    clr(); tick();
    rd_vld = 1'b1; rd_address = 1; tick();
    chk("lit two updates", rd_data, splat(UPD_EN ? 32'hB : 32'h5));

    clr(); wr_vld = 1'b1; wr_address = 1; wr_data = splat(32'h5); tick();
    clr(); upd_vld = 1'b1; upd_address = 1; upd_delta = splat(32'hFFFF_FFFA); tick();
    clr(); tick();
    rd_vld = 1'b1; rd_address = 1; tick();
    chk("lit negative delta", rd_data, splat(UPD_EN ? 32'hFFFF_FFFF : 32'h5));

    // Writeback cycle collides with a full write to another address
    clr(); upd_vld = 1'b1; upd_address = 1; upd_delta = splat(32'h1); tick();
    clr(); wr_vld = 1'b1; wr_address = 0; wr_data = splat(32'h77); tick();
    chk("lit wr_drop pulse", WW'(wr_drop), WW'(UPD_EN));
    clr(); tick();
    chk("lit wr_drop clears", WW'(wr_drop), WW'(0));
    rd_vld = 1'b1; rd_address = 0; tick();
    chk("lit dropped write", rd_data, UPD_EN ? ramp(32'hA0) : splat(32'h77));

    // Read and write to the same address in one cycle returns the old word
    clr(); wr_vld = 1'b1; wr_address = 3; wr_data = splat(32'h33); rd_vld = 1'b1; rd_address = 3; tick();
    chk("lit read before write", rd_data, ramp(32'h30));
    clr(); rd_vld = 1'b1; rd_address = 3; tick();
    chk("lit write visible", rd_data, splat(32'h33));

    // Interleave counters
    clr(); inter_first = 1'b1; tick();
    chk("lit first count_0", WW'(inter_count_0), WW'(0));
    inter_first = 1'b0; inter = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("lit count_0 seq", WW'(inter_count_0), WW'(seq0[k]));
    end
    chk("lit count_1 after 14", WW'(inter_count_1), WW'(2));
    inter = 1'b0; tick();
    chk("lit count_0 hold", WW'(inter_count_0), WW'(2));
    inter = 1'b1;
    repeat (10) tick();
    chk("lit count_1 wrap", WW'(inter_count_1), WW'(0));
    chk("lit count_0 at wrap", WW'(inter_count_0), WW'(0));
    repeat (9) tick();
    inter_first = 1'b1; tick();
    chk("lit restart count_0", WW'(inter_count_0), WW'(0));
    chk("lit restart count_1", WW'(inter_count_1), WW'(0));

    // Reset lands while an update is in flight
    clr(); inter = 1'b1; tick(); tick();
    clr(); upd_vld = 1'b1; upd_address = 2; upd_delta = splat(32'h100); rd_vld = 1'b1; rd_address = 2; tick();
    clr();
    #2 rst_n = 1'b0;
    tick();
    chk("lit reset rd_data_vld", WW'(rd_data_vld), WW'(0));
    chk("lit reset count_0", WW'(inter_count_0), WW'(0));
    chk("lit reset count_1", WW'(inter_count_1), WW'(0));
    rst_n = 1'b1; tick();
    rd_vld = 1'b1; rd_address = 2; tick();
    chk("lit update cancelled", rd_data, exp_sub);
    clr(); tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
